// File: rtl/latch_reader_pkg.sv
// Shared types and sizing helpers for the latch pair reader.
package latch_reader_pkg;

  localparam int unsigned TS_W           = 40;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_RST_HOLD   = 2;
  localparam int unsigned DEF_TIMEOUT    = 1024;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_TIMER_W = cnt_w(DEF_TIMEOUT);
  localparam int unsigned DEF_HOLD_W  = cnt_w(DEF_RST_HOLD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPTURE,
    ST_RELEASE,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [TS_W-1:0] delta;
    logic [TS_W-1:0] stamp;
  } entry_t;

endpackage

// File: rtl/latch_result_fifo.sv
// Synchronous first-word fall-through result queue.
module latch_result_fifo #(
  parameter int unsigned DATA_W = 80,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LVL_W-1:0]  count_q;
  logic              pop_en_c;
  logic              push_en_c;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

  // A pop frees the slot a same-cycle push needs; pops on empty are ignored.
  assign pop_en_c  = pop_i && !empty_o;
  assign push_en_c = push_i && (!full_o || pop_en_c);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_en_c) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_en_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + LVL_W'(push_en_c) - LVL_W'(pop_en_c);
    end
  end

endmodule

// File: rtl/latch_pair_reader.sv
// Captures both latched timestamps from the two-channel counter, queues
// their interval and releases the counter for the next pair.
module latch_pair_reader
  import latch_reader_pkg::*;
#(
  parameter int unsigned WIDTH      = TS_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned RST_HOLD   = DEF_RST_HOLD,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          iClk,
  input  logic                          iReset,
  input  logic [WIDTH-1:0]              iReg1,
  input  logic [WIDTH-1:0]              iReg2,
  input  logic                          iRdy1,
  input  logic                          iRdy2,
  output logic                          oRstLatch1,
  output logic                          oRstLatch2,
  output logic [WIDTH-1:0]              oDelta,
  output logic [WIDTH-1:0]              oStamp,
  output logic                          oValid,
  input  logic                          iReady,
  output logic                          oOverflow,
  output logic                          oOrphan,
  output logic [$clog2(FIFO_DEPTH):0]   oLevel
);

  localparam int unsigned TIMER_W = cnt_w(TIMEOUT);
  localparam int unsigned HOLD_W  = cnt_w(RST_HOLD);

  state_t               state_q;
  state_t               state_d;
  logic [TIMER_W-1:0]   timer_q;
  logic [TIMER_W-1:0]   timer_d;
  logic [HOLD_W-1:0]    hold_q;
  logic [HOLD_W-1:0]    hold_d;
  logic                 rdy1_meta_q;
  logic                 rdy1_sync_q;
  logic                 rdy2_meta_q;
  logic                 rdy2_sync_q;
  logic                 rst_latch_q;
  logic                 overflow_q;
  logic                 orphan_q;
  logic                 capture_c;
  logic                 orphan_set_c;
  logic                 drop_c;
  logic                 fifo_full_c;
  logic                 fifo_empty_c;
  entry_t               push_entry_c;
  entry_t               head_entry_c;

  // Interval wraps modulo 2^WIDTH; the counter keeps data stable while latched.
  assign push_entry_c.delta = iReg2 - iReg1;
  assign push_entry_c.stamp = iReg1;

  // A full queue only drops the pair if the sink is not popping this cycle.
  assign drop_c = capture_c && fifo_full_c && !iReady;

  // Two-flop synchronizers, state, timers and sticky flags.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      rdy1_meta_q <= 1'b0;
      rdy1_sync_q <= 1'b0;
      rdy2_meta_q <= 1'b0;
      rdy2_sync_q <= 1'b0;
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      hold_q      <= '0;
      rst_latch_q <= 1'b0;
      overflow_q  <= 1'b0;
      orphan_q    <= 1'b0;
    end else begin
      rdy1_meta_q <= iRdy1;
      rdy1_sync_q <= rdy1_meta_q;
      rdy2_meta_q <= iRdy2;
      rdy2_sync_q <= rdy2_meta_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      hold_q      <= hold_d;
      rst_latch_q <= (state_d == ST_RELEASE);
      overflow_q  <= overflow_q | drop_c;
      orphan_q    <= orphan_q | orphan_set_c;
    end
  end

  // Next-state logic for the capture / release handshake.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    hold_d       = hold_q;
    capture_c    = 1'b0;
    orphan_set_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rdy1_sync_q && rdy2_sync_q) begin
          state_d = ST_CAPTURE;
        end else if (rdy1_sync_q ^ rdy2_sync_q) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      end
      ST_WAIT: begin
        if (rdy1_sync_q && rdy2_sync_q) begin
          state_d = ST_CAPTURE;
        end else if (!rdy1_sync_q && !rdy2_sync_q) begin
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          orphan_set_c = 1'b1;
          state_d      = ST_RELEASE;
          hold_d       = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_CAPTURE: begin
        capture_c = 1'b1;
        state_d   = ST_RELEASE;
        hold_d    = '0;
      end
      ST_RELEASE: begin
        if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!rdy1_sync_q && !rdy2_sync_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  latch_result_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (iClk),
    .rst_i   (iReset),
    .push_i  (capture_c),
    .data_i  (push_entry_c),
    .pop_i   (iReady),
    .data_o  (head_entry_c),
    .full_o  (fifo_full_c),
    .empty_o (fifo_empty_c),
    .level_o (oLevel)
  );

  assign oRstLatch1 = rst_latch_q;
  assign oRstLatch2 = rst_latch_q;
  assign oValid     = !fifo_empty_c;
  assign oDelta     = head_entry_c.delta;
  assign oStamp     = head_entry_c.stamp;
  assign oOverflow  = overflow_q;
  assign oOrphan    = orphan_q;

endmodule

// File: tb/tb_latch_pair_reader.sv
// Bench for latch_pair_reader: directed vector table, corner sequences and a
// randomized run against a queue-based reference of expected results.
module tb_latch_pair_reader;

  localparam int unsigned W = 40;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    int           gap;
    bit           two_first;
    logic [W-1:0] exp_delta;
  } vec_t;

  typedef struct {
    logic [W-1:0] delta;
    logic [W-1:0] stamp;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] reg1 = '0;
  logic [W-1:0] reg2 = '0;
  logic         rdy1 = 1'b0;
  logic         rdy2 = 1'b0;
  logic         ready_dir = 1'b0;
  logic         ready_rand = 1'b1;
  logic         rand_en = 1'b0;
  logic         mon_en = 1'b0;
  logic         ready_w;
  logic         rst_l1, rst_l2, valid, overflow, orphan;
  logic [W-1:0] delta, stamp;
  logic [2:0]   level;

  int checks = 0;
  int errors = 0;
  int lo_streak = 0;
  exp_t exp_q[$];
  vec_t vecs[5];

  assign ready_w = rand_en ? ready_rand : ready_dir;

  always #5 clk = ~clk;

  latch_pair_reader #(
    .WIDTH(40), .FIFO_DEPTH(4), .RST_HOLD(2), .TIMEOUT(1024)
  ) dut (
    .iClk(clk), .iReset(rst), .iReg1(reg1), .iReg2(reg2),
    .iRdy1(rdy1), .iRdy2(rdy2), .oRstLatch1(rst_l1), .oRstLatch2(rst_l2),
    .oDelta(delta), .oStamp(stamp), .oValid(valid), .iReady(ready_w),
    .oOverflow(overflow), .oOrphan(orphan), .oLevel(level)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Counter model: latch both channels (optionally staggered), release on strobe.
  task automatic issue_pair(input logic [W-1:0] r1, input logic [W-1:0] r2,
                            input int gap, input bit two_first,
                            output bit found, output bit v, output logic [W-1:0] d,
                            output logic [W-1:0] s, output int lat, output int slen,
                            output bit both);
    found = 1'b0; v = 1'b0; d = '0; s = '0; lat = 0; slen = 0; both = 1'b0;
    @(negedge clk);
    reg1 = r1;
    reg2 = r2;
    if (gap > 0) begin
      if (two_first) rdy2 = 1'b1; else rdy1 = 1'b1;
      repeat (gap) @(negedge clk);
    end
    rdy1 = 1'b1;
    rdy2 = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      lat++;
      if (rst_l1) found = 1'b1;
    end
    if (found) begin
      v = valid; d = delta; s = stamp; both = rst_l2;
      slen = 1;
      rdy1 = 1'b0;
      rdy2 = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!rst_l1) break;
        slen++;
      end
    end else begin
      rdy1 = 1'b0;
      rdy2 = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  // Randomized sink backpressure, never low for more than three cycles.
  always @(posedge clk) begin
    #1;
    if (lo_streak >= 3 || $urandom_range(0, 3) != 0) begin
      ready_rand = 1'b1;
      lo_streak  = 0;
    end else begin
      ready_rand = 1'b0;
      lo_streak++;
    end
  end

  // Scoreboard: every accepted head entry must match the oldest expected result.
  always @(negedge clk) begin
    if (mon_en && valid && ready_w) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_pop: got delta %0h with empty reference queue", delta);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_delta", 64'(delta), 64'(e.delta));
        chk("sb_stamp", 64'(stamp), 64'(e.stamp));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit           found, v, both;
    logic [W-1:0] d, s;
    int           lat, slen;

    vecs[0] = '{r1: 40'd100,          r2: 40'd350,          gap: 0,  two_first: 1'b0, exp_delta: 40'd250};
    vecs[1] = '{r1: 40'hFFFFFFFFF0,   r2: 40'h10,           gap: 50, two_first: 1'b0, exp_delta: 40'h20};
    vecs[2] = '{r1: 40'd5,            r2: 40'd5,            gap: 3,  two_first: 1'b1, exp_delta: 40'd0};
    vecs[3] = '{r1: 40'd1000,         r2: 40'd1,            gap: 0,  two_first: 1'b0, exp_delta: 40'hFFFFFFFC19};
    vecs[4] = '{r1: 40'd0,            r2: 40'hFFFFFFFFFF,   gap: 7,  two_first: 1'b1, exp_delta: 40'hFFFFFFFFFF};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(valid), 0);
    chk("rst_level", 64'(level), 0);
    chk("rst_strobe1", 64'(rst_l1), 0);
    chk("rst_strobe2", 64'(rst_l2), 0);
    chk("rst_delta", 64'(delta), 0);
    chk("rst_stamp", 64'(stamp), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_orphan", 64'(orphan), 0);

    // Directed vector table with an always-ready sink
    ready_dir = 1'b1;
    foreach (vecs[i]) begin
      issue_pair(vecs[i].r1, vecs[i].r2, vecs[i].gap, vecs[i].two_first,
                 found, v, d, s, lat, slen, both);
      chk("vec_strobe_seen", 64'(found), 1);
      chk("vec_valid", 64'(v), 1);
      chk("vec_delta", 64'(d), 64'(vecs[i].exp_delta));
      chk("vec_stamp", 64'(s), 64'(vecs[i].r1));
      chk("vec_latency", 64'(lat), 4);
      chk("vec_strobe_len", 64'(slen), 2);
      chk("vec_strobe2", 64'(both), 1);
      chk("vec_level_after", 64'(level), 0);
      chk("vec_orphan", 64'(orphan), 0);
      chk("vec_overflow", 64'(overflow), 0);
    end

    // Orphan: channel 1 alone held for 1100 cycles
    begin
      int pulses = 0, orphan_at = 0, cyc = 0;
      bit prev = 1'b0, any_valid = 1'b0;
      do_reset();
      @(negedge clk);
      reg1 = 40'd55;
      rdy1 = 1'b1;
      for (int i = 0; i < 1110; i++) begin
        @(negedge clk);
        cyc++;
        if (rst_l1 && !prev) pulses++;
        prev = rst_l1;
        if (orphan && orphan_at == 0) orphan_at = cyc;
        if (valid) any_valid = 1'b1;
        if (cyc == 1100) rdy1 = 1'b0;
      end
      chk("orphan_set", 64'(orphan), 1);
      chk("orphan_time_in_range", 64'(orphan_at >= 1024 && orphan_at <= 1030), 1);
      chk("orphan_pulses", 64'(pulses), 1);
      chk("orphan_no_valid", 64'(any_valid), 0);
      chk("orphan_level", 64'(level), 0);
      chk("orphan_no_overflow", 64'(overflow), 0);
    end

    // Overflow: sink stalled, five pairs issued
    do_reset();
    ready_dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue_pair(40'(1000 * i), 40'(1000 * i + 10 + i), 0, 1'b0, found, v, d, s, lat, slen, both);
      chk("ovf_strobe_seen", 64'(found), 1);
      if (i == 3) chk("ovf_not_yet", 64'(overflow), 0);
    end
    chk("ovf_level", 64'(level), 4);
    chk("ovf_flag", 64'(overflow), 1);
    ready_dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_valid", 64'(valid), 1);
      chk("ovf_drain_delta", 64'(delta), 64'(10 + i));
      chk("ovf_drain_stamp", 64'(stamp), 64'(1000 * i));
      @(negedge clk);
    end
    chk("ovf_drained_valid", 64'(valid), 0);
    chk("ovf_drained_level", 64'(level), 0);
    chk("ovf_sticky", 64'(overflow), 1);

    // Full queue with a pop on the capture cycle
    do_reset();
    ready_dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_pair(40'(50 * i), 40'(50 * i + 20 + i), 0, 1'b0, found, v, d, s, lat, slen, both);
    end
    chk("fp_level_full", 64'(level), 4);
    @(negedge clk);
    reg1 = 40'd200;
    reg2 = 40'd224;
    rdy1 = 1'b1;
    rdy2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ready_dir = 1'b1;
    @(negedge clk);
    ready_dir = 1'b0;
    chk("fp_strobe", 64'(rst_l1), 1);
    chk("fp_level", 64'(level), 4);
    chk("fp_overflow", 64'(overflow), 0);
    chk("fp_head", 64'(delta), 21);
    rdy1 = 1'b0;
    rdy2 = 1'b0;
    repeat (6) @(negedge clk);
    ready_dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fp_drain_delta", 64'(delta), 64'(21 + i));
      @(negedge clk);
    end
    chk("fp_drained", 64'(valid), 0);

    // Reset in the second release cycle with the counter still latched
    begin
      bit seen = 1'b0;
      do_reset();
      ready_dir = 1'b0;
      @(negedge clk);
      reg1 = 40'd7;
      reg2 = 40'd107;
      rdy1 = 1'b1;
      rdy2 = 1'b1;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (rst_l1) seen = 1'b1;
      end
      chk("mr_first_strobe", 64'(seen), 1);
      @(negedge clk);
      chk("mr_second_release", 64'(rst_l1), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mr_strobe1_drop", 64'(rst_l1), 0);
      chk("mr_strobe2_drop", 64'(rst_l2), 0);
      chk("mr_valid_zero", 64'(valid), 0);
      chk("mr_level_zero", 64'(level), 0);
      chk("mr_delta_zero", 64'(delta), 0);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (rst_l1) seen = 1'b1;
      end
      chk("mr_recapture", 64'(seen), 1);
      chk("mr_delta", 64'(delta), 100);
      chk("mr_stamp", 64'(stamp), 7);
      rdy1 = 1'b0;
      rdy2 = 1'b0;
      repeat (30) @(negedge clk);
      chk("mr_single_capture", 64'(level), 1);
    end

    // Randomized pairs against the reference queue
    do_reset();
    rand_en = 1'b1;
    mon_en  = 1'b1;
    for (int n = 0; n < 30; n++) begin
      logic [63:0] t1, t2;
      logic [W-1:0] r1, r2;
      exp_t e;
      t1 = {$urandom(), $urandom()};
      t2 = {$urandom(), $urandom()};
      r1 = t1[W-1:0];
      r2 = t2[W-1:0];
      e.delta = r2 - r1;
      e.stamp = r1;
      exp_q.push_back(e);
      issue_pair(r1, r2, int'($urandom_range(0, 20)), bit'($urandom_range(0, 1)),
                 found, v, d, s, lat, slen, both);
      chk("rnd_strobe_seen", 64'(found), 1);
      chk("rnd_strobe_len", 64'(slen), 2);
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("rnd_all_drained", 64'(exp_q.size()), 0);
    chk("rnd_overflow", 64'(overflow), 0);
    chk("rnd_orphan", 64'(orphan), 0);
    mon_en  = 1'b0;
    rand_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
